// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit path (and the planned receiver).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int CLKS_PER_BIT_115200 = 868;

    // Payload is zero-extended to 9 bits; the padding does not disturb the XOR.
    function automatic logic parity_bit(input parity_e mode, input logic [8:0] data);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an extra pointer MSB to tell full from empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic          full,
    input  logic          rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        level    = wr_ptr_q - rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a local FIFO; queued words leave back-to-back.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int      CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int      DATA_BITS    = 8,
    parameter parity_e PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          enable,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              CW         = $clog2(CLKS_PER_BIT);
    localparam int              BW         = 4;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [BW-1:0]   BIT_ONE    = BW'(1);
    localparam logic [BW-1:0]   DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]   STOP_LAST  = BW'(STOP_BITS - 1);
    localparam bit              HAS_PARITY = (PARITY != PAR_NONE);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 bit_done, start_ok, load;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        load      = 1'b0;
        bit_done  = (cnt_q == CNT_LAST);
        start_ok  = enable && !fifo_empty;

        if (state_q != ST_IDLE) cnt_d = bit_done ? '0 : cnt_q + CNT_ONE;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) load = 1'b1;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == DATA_LAST) begin
                        state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_idx_q == STOP_LAST) begin
                        if (start_ok) begin
                            load = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_idx_d = '0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d   = ST_START;
            cnt_d     = '0;
            bit_idx_d = '0;
            shift_d   = fifo_rd_data;
            par_d     = parity_bit(PARITY, 9'(fifo_rd_data));
        end
        fifo_pop = load;
    end

    // Line level is decoded from the next state so uart_tx can be a plain flop.
    always_comb begin
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign s_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four configurations of uart_tx_fifo sharing one clock and reset.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic       v0, v1, v2, v3;
    logic       en0, en1, en2, en3;
    logic       r0, r1, r2, r3;
    logic       tx0, tx1, tx2, tx3;
    logic       b0, b1, b2, b3;
    logic [4:0] l0;
    logic [2:0] l1, l2, l3;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(uart_pkg::PAR_NONE),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_n81 (
        .clk(clk), .rst(rst), .s_data(d0), .s_valid(v0), .s_ready(r0),
        .enable(en0), .uart_tx(tx0), .busy(b0), .fifo_level(l0));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(uart_pkg::PAR_EVEN),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst(rst), .s_data(d1), .s_valid(v1), .s_ready(r1),
        .enable(en1), .uart_tx(tx1), .busy(b1), .fifo_level(l1));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(uart_pkg::PAR_ODD),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst(rst), .s_data(d2), .s_valid(v2), .s_ready(r2),
        .enable(en2), .uart_tx(tx2), .busy(b2), .fifo_level(l2));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(uart_pkg::PAR_NONE),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_d7s2 (
        .clk(clk), .rst(rst), .s_data(d3), .s_valid(v3), .s_ready(r3),
        .enable(en3), .uart_tx(tx3), .busy(b3), .fifo_level(l3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic [8:0] d, input logic v);
        case (i)
            0: begin d0 = d[7:0]; v0 = v; end
            1: begin d1 = d[7:0]; v1 = v; end
            2: begin d2 = d[7:0]; v2 = v; end
            default: begin d3 = d[6:0]; v3 = v; end
        endcase
    endtask

    function automatic logic get_tx(input int i);
        case (i)
            0: return tx0;
            1: return tx1;
            2: return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic get_busy(input int i);
        case (i)
            0: return b0;
            1: return b1;
            2: return b2;
            default: return b3;
        endcase
    endfunction

    // Expected 8N1 line level for frame bit b (0 = start, 9 = stop).
    function automatic logic f81(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        return 1'b1;
    endfunction

    // Push one word, then follow the whole frame; exp holds the line level per bit period.
    task automatic run_frame(input int i, input logic [8:0] data, input int nbits,
                             input logic [11:0] exp, input string tag);
        @(negedge clk);
        drive(i, data, 1'b1);
        @(negedge clk);
        drive(i, 9'h0, 1'b0);
        chk({tag, "_pre_tx"}, get_tx(i), 1'b1);
        chk({tag, "_pre_busy"}, get_busy(i), 1'b0);
        @(negedge clk);
        for (int k = 0; k < nbits * 4; k++) begin
            chk({tag, "_tx"}, get_tx(i), exp[k/4]);
            chk({tag, "_busy"}, get_busy(i), 1'b1);
            @(negedge clk);
        end
        chk({tag, "_end_tx"}, get_tx(i), 1'b1);
        chk({tag, "_end_busy"}, get_busy(i), 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_tx0", tx0, 1'b1);
        chk("rst_tx1", tx1, 1'b1);
        chk("rst_tx2", tx2, 1'b1);
        chk("rst_tx3", tx3, 1'b1);
        chk("rst_busy", {b3, b2, b1, b0}, 4'h0);
        chk("rst_ready", {r3, r2, r1, r0}, 4'hF);
        chk("rst_lvl0", l0, 5'd0);
        chk("rst_lvl123", {l3, l2, l1}, 9'd0);

        rst = 1'b1;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;

        // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
        run_frame(0, 9'h0A5, 10, 12'h34A, "n81");
        // 0x07 with parity: even -> 1, odd -> 0
        run_frame(1, 9'h007, 11, 12'h60E, "even");
        run_frame(2, 9'h007, 11, 12'h40E, "odd");
        // 0x7F, 7 data bits, 2 stop bits
        run_frame(3, 9'h07F, 10, 12'h3FE, "d7s2");

        // Fill with transmitter held off; the 17th word must be refused.
        @(negedge clk);
        en0 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(0, 9'(8'h30 + i), 1'b1);
            chk("fill_ready", r0, (i < 16) ? 1'b1 : 1'b0);
            @(negedge clk);
            chk("fill_level", l0, (i < 16) ? 5'(i + 1) : 5'd16);
        end
        drive(0, 9'h0, 1'b0);
        chk("full_ready", r0, 1'b0);
        chk("full_level", l0, 5'd16);

        en0 = 1'b1;
        @(negedge clk);
        chk("drain_level", l0, 5'd15);
        for (int j = 0; j < 16; j++) begin
            for (int c = 0; c < 40; c++) begin
                chk("drain_tx", tx0, f81(8'(8'h30 + j), c / 4));
                chk("drain_busy", b0, 1'b1);
                @(negedge clk);
            end
        end
        chk("drain_end_tx", tx0, 1'b1);
        chk("drain_end_busy", b0, 1'b0);
        chk("drain_end_level", l0, 5'd0);
        chk("drain_end_ready", r0, 1'b1);

        // Reset in the middle of a data bit with 3 words still queued.
        en0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 9'(i * 8'h11), 1'b1);
            @(negedge clk);
        end
        drive(0, 9'h0, 1'b0);
        en0 = 1'b1;
        @(negedge clk);
        chk("rstmid_level", l0, 5'd3);
        repeat (8) @(negedge clk);
        chk("rstmid_data_low", tx0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_tx", tx0, 1'b1);
        chk("rstmid_busy", b0, 1'b0);
        chk("rstmid_lvl", l0, 5'd0);
        chk("rstmid_ready", r0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("post_rst_tx", tx0, 1'b1);
            chk("post_rst_busy", b0, 1'b0);
        end
        // 0x5A after reset: 0,0,1,0,1,1,0,1,0,1
        run_frame(0, 9'h05A, 10, 12'h2B4, "post_rst");

        // Drop enable during the first of three queued frames.
        en0 = 1'b0;
        drive(0, 9'h0C3, 1'b1);
        @(negedge clk);
        drive(0, 9'h03C, 1'b1);
        @(negedge clk);
        drive(0, 9'h081, 1'b1);
        @(negedge clk);
        drive(0, 9'h0, 1'b0);
        en0 = 1'b1;
        @(negedge clk);
        chk("endrop_level", l0, 5'd2);
        for (int c = 0; c < 40; c++) begin
            if (c == 10) en0 = 1'b0;
            chk("endrop_tx", tx0, f81(8'hC3, c / 4));
            @(negedge clk);
        end
        for (int c = 0; c < 60; c++) begin
            chk("endrop_idle_tx", tx0, 1'b1);
            chk("endrop_idle_busy", b0, 1'b0);
            @(negedge clk);
        end
        chk("endrop_hold_level", l0, 5'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It replaces the vendor UART-lite core and its AXI-lite write controller on the transmit path. Upstream logic pushes words over a valid/ready stream. The block serialises them onto `uart_tx` with configurable word width, parity, stop bits and bit period, and sends queued words back-to-back.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `DATA_BITS`, 8: payload bits per frame; legal range 5–9.
- `PARITY`, `PAR_NONE`: one of `PAR_NONE`, `PAR_ODD`, `PAR_EVEN` (from `uart_pkg`).
- `STOP_BITS`, 1: legal values 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_BITS  word to transmit.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  FIFO can accept a word; equals !full.
- `enable`  in  1  transmitter may start new frames.
- `uart_tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words queued, not counting the word being sent.

## Operation
- A push occurs when `s_valid && s_ready` on a rising edge. If the FIFO is full, `s_ready` is 0 and `s_data` is ignored; no overwrite occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: when `enable && !empty`. The FIFO is popped on the same edge and the word is loaded into the shift register.
  - START → DATA: after one bit period.
  - DATA → PARITY, or DATA → STOP when `PARITY == PAR_NONE`: after DATA_BITS bit periods.
  - PARITY → STOP: after one bit period.
  - STOP ends after STOP_BITS bit periods. If `enable && !empty` at that point, go directly to START with a pop, leaving no idle gap. Otherwise go to IDLE.
- Line levels by state: START drives 0; DATA drives data LSB first; PARITY drives the parity bit; STOP and IDLE drive 1.
- Parity is computed over the DATA_BITS payload only:
  - even: `^data`
  - odd: `~^data`
- Bit timer: counts from 0 up to CLKS_PER_BIT-1, then wraps and advances the bit. The timer and bit index reset to 0 on every state entry.
- Deasserting `enable` mid-frame does not abort the frame. The current frame completes and no further frame starts.
- Push and pop in the same cycle: `fifo_level` is unchanged and both operations occur. When the FIFO is empty, a push is not visible to the FSM until the next cycle; there is no bypass path.
- Reset values: `uart_tx`=1, `busy`=0, `s_ready`=1, `fifo_level`=0, state=IDLE, FIFO pointers=0.
- Reset asserted mid-frame: `uart_tx` returns to 1 asynchronously and the FIFO contents are discarded.

## Timing
- `uart_tx`, `busy` and `s_ready` are registered outputs.
- Latency from push to first start bit, with enable=1, FIFO empty and IDLE:
  - push edge at cycle 0;
  - pop edge at the end of cycle 1;
  - `uart_tx` is low from cycle 2.
- Frame length is CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS) cycles, where P = 1 if parity is enabled, else 0.
- Queued words are sent back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `fifo_level` and `s_ready` update on the edge following a push or pop.

## Structure
- `uart_pkg` holds:
  - the `parity_e` enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`);
  - the `tx_state_e` enum;
  - the default constant `CLKS_PER_BIT_115200`.
- Sub-module `uart_sync_fifo`, parametrised by WIDTH and DEPTH:
  - extra pointer MSB for full/empty detection;
  - `level` output;
  - reusable later by the planned receiver.
- `uart_tx_fifo` holds the FSM, bit timer, shift register and parity logic.

## Test plan
- 8N1, CLKS_PER_BIT=4: push 0xA5.
  - `uart_tx` low at cycle 2 after the push.
  - Serial sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - Frame is 40 cycles; `busy` is high for exactly 40 cycles.
- PARITY=PAR_EVEN: push 0x07 → parity bit 1. Same stimulus with PAR_ODD → parity bit 0. Both frames are 44 cycles.
- enable=0, push 17 words:
  - `s_ready` drops after the 16th word; the 17th is dropped; `fifo_level`=16.
  - Raise enable → 16 frames back-to-back with no idle cycles, in push order.
- DATA_BITS=7, STOP_BITS=2: push 0x7F → 7 ones after the start bit, then 2 stop periods; frame is 40 cycles at CLKS_PER_BIT=4.
- Assert rst mid-DATA with 3 words queued:
  - `uart_tx`=1 immediately; `fifo_level`=0; `busy`=0.
  - After release, no frame is sent until a new push.
- Drop enable mid-frame with 2 words queued → the current frame completes, the line stays idle, and `fifo_level`=2 is held.
